// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// The defaults here match the arbiter's default parameters.
package arb_pkg;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_WEIGHT_W = 3;
    localparam int IDX_W        = $clog2(ARB_NUM_REQ);

    typedef logic [ARB_WEIGHT_W-1:0] weight_t;

    // Index of the set bit of a one-hot vector; 0 when no bit is set.
    // Supports up to 32 requesters.
    function automatic int unsigned onehot2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority picker: returns the first set request
// at or after start_i, wrapping modulo N.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int W2 = 2 * N;
    localparam int IW = $clog2(N);

    logic [W2-1:0] req2;
    logic [W2-1:0] masked;
    logic [W2-1:0] lowest;

    // The upper copy supplies the wrapped requests below start_i.
    assign req2    = {req_i, req_i};
    assign masked  = req2 & ({W2{1'b1}} << start_i);
    assign lowest  = masked & (~masked + W2'(1));
    assign gnt_o   = lowest[N-1:0] | lowest[W2-1:N];
    assign valid_o = |req_i;
    assign idx_o   = IW'(onehot2idx(32'(gnt_o)));

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: an owner keeps the grant for up to its
// weight of acknowledged beats, releasing early when it drops its request.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int WEIGHT_W = ARB_WEIGHT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic                         ack_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id_o,
    output logic                         gnt_valid_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     cur_q, cur_d;
    logic                own_q, own_d;
    logic [WEIGHT_W-1:0] cred_q, cred_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_id;
    logic                pick_vld;
    logic                own_hit;
    logic                beat;

    logic [NUM_REQ-1:0][WEIGHT_W-1:0] w_arr;
    logic [WEIGHT_W-1:0]              w_sel;
    logic [WEIGHT_W-1:0]              w_eff;

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_i),
        .start_i (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_id),
        .valid_o (pick_vld)
    );

    assign own_hit = own_q & req_i[cur_q];
    assign w_arr   = weight_i;

    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        if (!reset) begin
            if (own_hit) begin
                gnt_o[cur_q] = 1'b1;
                gnt_id_o     = cur_q;
                gnt_valid_o  = 1'b1;
            end else begin
                gnt_o       = pick_gnt;
                gnt_id_o    = pick_id;
                gnt_valid_o = pick_vld;
            end
        end
    end

    assign beat  = gnt_valid_o & ack_i;
    assign w_sel = w_arr[gnt_id_o];
    assign w_eff = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;

    always_comb begin
        ptr_d  = ptr_q;
        cur_d  = cur_q;
        own_d  = own_q;
        cred_d = cred_q;
        // An owner that withdrew loses the burst; ptr_q already points past it.
        if (own_q && !req_i[cur_q]) own_d = 1'b0;
        if (beat) begin
            if (own_hit) begin
                if (cred_q <= WEIGHT_W'(1)) own_d  = 1'b0;
                else                        cred_d = cred_q - WEIGHT_W'(1);
            end else begin
                ptr_d = (gnt_id_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_o + ID_W'(1);
                cur_d = gnt_id_o;
                if (w_eff == WEIGHT_W'(1)) begin
                    own_d = 1'b0;
                end else begin
                    own_d  = 1'b1;
                    cred_d = w_eff - WEIGHT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            cur_q  <= '0;
            own_q  <= 1'b0;
            cred_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cur_q  <= cur_d;
            own_q  <= own_d;
            cred_q <= cred_d;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with literal expectations plus
// a randomized run, all compared against a behavioural grant model.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_i;
    logic              ack_i;
    logic [N*WW-1:0]   weight_i;
    logic [N-1:0]      gnt_o;
    logic [1:0]        gnt_id_o;
    logic              gnt_valid_o;

    int checks = 0;
    int errors = 0;

    // Model: next search start, current burst owner (-1 = none), beats left.
    int m_start;
    int m_owner;
    int m_left;

    wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .weight_i    (weight_i),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        if (m_owner >= 0 && req_i[m_owner]) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (req_i[(m_start + k) % N]) return (m_start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update(input int e);
        bit cont;
        int w;
        cont = (m_owner >= 0) && req_i[m_owner];
        if (m_owner >= 0 && !req_i[m_owner]) m_owner = -1;
        if (e >= 0 && ack_i) begin
            if (cont) begin
                m_left = m_left - 1;
                if (m_left <= 0) m_owner = -1;
            end else begin
                w = int'(weight_i[e*WW +: WW]);
                if (w == 0) w = 1;
                m_start = (e + 1) % N;
                if (w > 1) begin
                    m_owner = e;
                    m_left  = w - 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endfunction

    // One cycle: drive after posedge, check at negedge, then advance the model.
    task automatic cyc(input logic [N-1:0] r, input logic a, input logic [N*WW-1:0] w,
                       input string tag, input int exp_gnt);
        int e;
        logic [N-1:0] mg;
        @(posedge clk); #1;
        req_i = r; ack_i = a; weight_i = w;
        @(negedge clk);
        e  = model_pick();
        mg = '0;
        if (e >= 0) mg[e] = 1'b1;
        check({tag, ".gnt"}, 32'(gnt_o), 32'(mg));
        check({tag, ".id"}, 32'(gnt_id_o), (e < 0) ? 32'd0 : 32'(e));
        check({tag, ".vld"}, 32'(gnt_valid_o), (e < 0) ? 32'd0 : 32'd1);
        if (exp_gnt >= 0) check({tag, ".lit"}, 32'(gnt_o), 32'(exp_gnt));
        model_update(e);
    endtask

    task automatic do_reset(input logic [N-1:0] r, input string tag);
        @(posedge clk); #1;
        reset = 1'b1; req_i = r; ack_i = 1'b1;
        @(negedge clk);
        check({tag, ".rst_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, ".rst_id"}, 32'(gnt_id_o), 32'd0);
        check({tag, ".rst_vld"}, 32'(gnt_valid_o), 32'd0);
        m_start = 0; m_owner = -1; m_left = 0;
        @(posedge clk); #1;
        reset = 1'b0; req_i = '0; ack_i = 1'b0;
    endtask

    logic [N*WW-1:0] w1 = {3'd1, 3'd1, 3'd1, 3'd1};
    logic [N-1:0]    rr;
    logic [N*WW-1:0] ww;

    initial begin
        reset = 1'b1; req_i = '0; ack_i = 1'b0; weight_i = w1;
        m_start = 0; m_owner = -1; m_left = 0;

        // 1: reset forces zero grant, then 1011 round-robin
        do_reset(4'b1111, "t1");
        cyc(4'b1011, 1'b1, w1, "t1a", 4'b0001);
        cyc(4'b1011, 1'b1, w1, "t1b", 4'b0010);
        cyc(4'b1011, 1'b1, w1, "t1c", 4'b1000);

        // 2: full request, pointer wraps
        do_reset(4'b0000, "t2");
        cyc(4'b1111, 1'b1, w1, "t2a", 4'b0001);
        cyc(4'b1111, 1'b1, w1, "t2b", 4'b0010);
        cyc(4'b1111, 1'b1, w1, "t2c", 4'b0100);
        cyc(4'b1111, 1'b1, w1, "t2d", 4'b1000);
        cyc(4'b1111, 1'b1, w1, "t2e", 4'b0001);

        // 3: weight 3 vs weight 1
        do_reset(4'b0000, "t3");
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t3a", 4'b0001);
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t3b", 4'b0001);
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t3c", 4'b0001);
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t3d", 4'b0010);
        end

        // 4: backpressure holds the grant
        do_reset(4'b0000, "t4");
        for (int i = 0; i < 3; i++) cyc(4'b0110, 1'b0, w1, "t4hold", 4'b0010);
        cyc(4'b0110, 1'b1, w1, "t4beat", 4'b0010);
        cyc(4'b0110, 1'b0, w1, "t4next", 4'b0100);

        // 5: owner drop and fresh credit on re-request
        do_reset(4'b0000, "t5");
        cyc(4'b0101, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t5a", 4'b0001);
        cyc(4'b0100, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t5drop", 4'b0100);
        for (int i = 0; i < 3; i++)
            cyc(4'b0101, 1'b1, {3'd1, 3'd1, 3'd1, 3'd3}, "t5re", 4'b0001);

        // 6: zero weight acts as one
        do_reset(4'b0000, "t6");
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd0}, "t6a", 4'b0001);
            cyc(4'b0011, 1'b1, {3'd1, 3'd1, 3'd1, 3'd0}, "t6b", 4'b0010);
        end

        // 7: reset mid-burst
        do_reset(4'b0000, "t7");
        cyc(4'b1000, 1'b1, {3'd4, 3'd1, 3'd1, 3'd1}, "t7a", 4'b1000);
        cyc(4'b1000, 1'b1, {3'd4, 3'd1, 3'd1, 3'd1}, "t7b", 4'b1000);
        do_reset(4'b1000, "t7mid");
        cyc(4'b1001, 1'b1, {3'd4, 3'd1, 3'd1, 3'd1}, "t7c", 4'b0001);

        // Randomized traffic against the model
        rr = 4'b1111;
        ww = w1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(4'($urandom), "rnd");
            end else begin
                if ($urandom_range(0, 9) == 0) ww = (N*WW)'($urandom);
                if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
                cyc(rr, $urandom_range(0, 3) != 0, ww, "rnd", -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
